// File: rtl/seg_disp_ctrl.sv
// seg_disp_ctrl: register-mapped digit buffer for the 7-segment scanner.
// Hex or double-dabble decimal load, leading-zero blanking and blink.
module seg_disp_ctrl #(
  parameter int DIGITS   = 8,
  parameter int IN_CLOCK = 50_000_000,
  parameter int BLINK_HZ = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  addr,
  input  logic [7:0]  wdata,
  input  logic        we,
  input  logic        re,
  output logic [7:0]  rdata,
  output logic [31:0] dig,
  output logic [7:0]  dig_en,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  localparam int HALF    = IN_CLOCK / (2 * BLINK_HZ);
  localparam int PRE_MAX = (HALF > 1) ? HALF - 1 : 0;

  state_t      state, state_nx;
  logic [15:0] bin;
  logic [19:0] bcd, bcd_adj;
  logic [4:0]  cnt;
  logic [7:0]  bin_l, blink, enable, lz, rd_mux;
  logic [1:0]  mode;
  logic        err, phase, seen;
  logic [31:0] pre;
  logic        wr_binh, wr_dig, start, set_err;

  assign busy    = (state != IDLE);
  assign wr_binh = we && (addr == 3'd1);
  assign wr_dig  = we && (addr == 3'd6);
  assign start   = wr_binh && !busy;
  assign set_err = busy && (wr_binh || wr_dig);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = mode[0] ? CONV : LOAD;
      CONV: if (cnt == 5'd15) state_nx = LOAD;
      LOAD: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 5; i++)
      if (bcd[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  // hex loads go straight into bcd so LOAD has one source
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      bin   <= '0;
      bcd   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: if (start) begin
          bin <= {wdata, bin_l};
          cnt <= '0;
          bcd <= mode[0] ? 20'h0 : {4'h0, wdata, bin_l};
        end
        CONV: begin
          {bcd, bin} <= {bcd_adj[18:0], bin, 1'b0};
          cnt        <= cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dig <= '0;
    end else if (state == LOAD) begin
      dig <= {12'h0, bcd};
    end else if (wr_dig && !busy && int'(wdata[6:4]) < DIGITS) begin
      dig[{wdata[6:4], 2'b00} +: 4] <= wdata[3:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bin_l  <= '0;
      mode   <= '0;
      blink  <= '0;
      enable <= 8'hFF;
    end else if (we) begin
      unique case (1'b1)
        (addr == 3'd0): bin_l  <= wdata;
        (addr == 3'd2): mode   <= wdata[1:0];
        (addr == 3'd3): blink  <= wdata;
        (addr == 3'd4): enable <= wdata;
        default: ;
      endcase
    end
  end

  // a new error wins over a clearing STATUS read
  always_ff @(posedge clk) begin
    if (!rst)
      err <= 1'b0;
    else if (set_err)
      err <= 1'b1;
    else if (re && addr == 3'd5)
      err <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pre   <= '0;
      phase <= 1'b0;
    end else if (pre == 32'(PRE_MAX)) begin
      pre   <= '0;
      phase <= ~phase;
    end else begin
      pre <= pre + 32'd1;
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    unique case (1'b1)
      (addr == 3'd0): rd_mux = bin_l;
      (addr == 3'd2): rd_mux = {6'b0, mode};
      (addr == 3'd3): rd_mux = blink;
      (addr == 3'd4): rd_mux = enable;
      (addr == 3'd5): rd_mux = {5'b0, err, phase, busy};
      default: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst)
      rdata <= '0;
    else if (re)
      rdata <= rd_mux;
  end

  always_comb begin
    lz   = '0;
    seen = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      seen  = seen | (dig[4*i +: 4] != 4'h0);
      lz[i] = mode[1] & ~seen & (i != 0);
    end
  end

  always_comb begin
    dig_en = '0;
    for (int i = 0; i < 8; i++)
      dig_en[i] = enable[i] & ~(blink[i] & phase)
                & ~lz[i] & (i < DIGITS);
  end

endmodule

// File: tb/tb_seg_disp_ctrl.sv
// tb_seg_disp_ctrl: directed stimulus with a cycle-stamped scoreboard.
// Stimulus queues expectations; the monitor compares when they fall due.
module tb_seg_disp_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  addr;
  logic [7:0]  wdata;
  logic        we, re;
  logic [7:0]  rdata;
  logic [31:0] dig;
  logic [7:0]  dig_en;
  logic        busy;

  seg_disp_ctrl #(
    .DIGITS(8), .IN_CLOCK(8), .BLINK_HZ(1)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata),
    .we(we), .re(re), .rdata(rdata), .dig(dig),
    .dig_en(dig_en), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    int          kind;
    logic [31:0] exp;
    logic [31:0] mask;
    string       name;
  } item_t;

  item_t       q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned r_rel   = 0;
  logic [31:0] act;

  function automatic logic [31:0] sel(int k);
    case (k)
      0:       return {24'h0, rdata};
      1:       return dig;
      2:       return {24'h0, dig_en};
      default: return {31'h0, busy};
    endcase
  endfunction

  // blink phase from the cycle count since reset release (toggle every 4)
  function automatic logic phase_at(int unsigned k);
    return (((k - r_rel) / 4) % 2) == 1;
  endfunction

  always begin
    @(negedge clk);
    #1;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        act = sel(q[i].kind);
        n_tests++;
        if ((act & q[i].mask) !== (q[i].exp & q[i].mask)) begin
          n_fail++;
          $display("FAIL %s @cyc %0d: got %h, expected %h",
                   q[i].name, cyc, act & q[i].mask,
                   q[i].exp & q[i].mask);
        end
        q.delete(i);
      end
    end
  end

  task automatic expect_at(int unsigned t, int k, logic [31:0] e,
                           logic [31:0] m, string nm);
    item_t it;
    it.cyc = t; it.kind = k; it.exp = e; it.mask = m; it.name = nm;
    q.push_back(it);
  endtask

  task automatic wr(logic [2:0] a, logic [7:0] d);
    addr = a; wdata = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(logic [2:0] a, logic [7:0] e, logic [7:0] m,
                    string nm);
    addr = a; re = 1'b1;
    expect_at(cyc + 1, 0, {24'h0, e}, {24'h0, m}, nm);
    @(negedge clk);
    re = 1'b0;
  endtask

  task automatic wait_to(int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c, t;
    rst = 1'b0; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    r_rel = cyc;
    expect_at(cyc, 0, 32'h0, 32'hFF, "rst_rdata");
    expect_at(cyc, 1, 32'h0, '1, "rst_dig");
    expect_at(cyc, 2, 32'hFF, 32'hFF, "rst_dig_en");
    expect_at(cyc, 3, 32'h0, 32'h1, "rst_busy");
    @(negedge clk);
    rd(3'd5, 8'h00, 8'hFF, "rst_status");

    // decimal 12345
    wr(3'd2, 8'h01);
    wr(3'd0, 8'h39);
    c = cyc;
    for (int k = 1; k <= 17; k++)
      expect_at(c + k, 3, 32'h1, 32'h1, "dec_busy");
    expect_at(c + 18, 3, 32'h0, 32'h1, "dec_busy_end");
    expect_at(c + 18, 1, 32'h0001_2345, '1, "dec_dig");
    expect_at(c + 18, 2, 32'hFF, 32'hFF, "dec_dig_en");
    wr(3'd1, 8'h30);
    wait_to(c + 19);

    // same value with LZS: blanking applies as soon as MODE changes
    c = cyc;
    expect_at(c + 1, 2, 32'h1F, 32'hFF, "lzs_now");
    wr(3'd2, 8'h03);
    c = cyc;
    expect_at(c + 1, 3, 32'h1, 32'h1, "lzs_busy");
    expect_at(c + 18, 3, 32'h0, 32'h1, "lzs_busy_end");
    expect_at(c + 18, 1, 32'h0001_2345, '1, "lzs_dig");
    expect_at(c + 18, 2, 32'h1F, 32'hFF, "lzs_dig_en");
    wr(3'd1, 8'h30);
    wait_to(c + 19);

    // hex BEEF
    wr(3'd2, 8'h00);
    wr(3'd0, 8'hEF);
    c = cyc;
    expect_at(c + 1, 3, 32'h1, 32'h1, "hex_busy");
    expect_at(c + 1, 1, 32'h0001_2345, '1, "hex_dig_old");
    expect_at(c + 2, 3, 32'h0, 32'h1, "hex_busy_end");
    expect_at(c + 2, 1, 32'h0000_BEEF, '1, "hex_dig");
    expect_at(c + 2, 2, 32'hFF, 32'hFF, "hex_dig_en");
    wr(3'd1, 8'hBE);
    wait_to(c + 3);

    // writes during decimal conversion of 255
    wr(3'd2, 8'h01);
    wr(3'd0, 8'hFF);
    c = cyc;
    expect_at(c + 17, 3, 32'h1, 32'h1, "err_busy_last");
    expect_at(c + 18, 3, 32'h0, 32'h1, "err_busy_end");
    expect_at(c + 18, 1, 32'h0000_0255, '1, "err_dig");
    wr(3'd1, 8'h00);
    wait_to(c + 3);
    wr(3'd0, 8'h11);
    wr(3'd1, 8'h12);
    wr(3'd6, 8'h37);
    wait_to(c + 20);
    rd(3'd5, 8'h04, 8'h05, "status_err_set");
    rd(3'd5, 8'h00, 8'h05, "status_err_clr");
    expect_at(cyc + 1, 1, 32'h0000_7255, '1, "digwr");
    wr(3'd6, 8'h37);

    // register readback and rdata hold
    wr(3'd2, 8'hFD);
    rd(3'd2, 8'h01, 8'hFF, "mode_rd");
    rd(3'd7, 8'h00, 8'hFF, "addr7_rd");
    rd(3'd0, 8'h11, 8'hFF, "binl_rd");
    expect_at(cyc + 2, 0, 32'h11, 32'hFF, "rdata_hold");
    c = cyc;
    expect_at(c + 1, 2, 32'h0F, 32'hFF, "lzs_digwr");
    wr(3'd2, 8'h03);
    expect_at(cyc + 1, 2, 32'h07, 32'hFF, "lzs_digwr_zero");
    wr(3'd6, 8'h30);

    // all-zero value: digit 0 stays lit
    wr(3'd2, 8'h02);
    wr(3'd0, 8'h00);
    c = cyc;
    expect_at(c + 2, 1, 32'h0, '1, "zero_dig");
    expect_at(c + 2, 2, 32'h01, 32'hFF, "zero_dig_en");
    wr(3'd1, 8'h00);
    wait_to(c + 3);

    // blink digit 0
    wr(3'd2, 8'h00);
    c = cyc;
    for (int k = 1; k <= 8; k++) begin
      t = c + k;
      expect_at(t, 2, phase_at(t) ? 32'hFE : 32'hFF, 32'hFF,
                "blink");
    end
    wr(3'd3, 8'h01);
    wait_to(c + 9);
    wr(3'd3, 8'h00);
    expect_at(cyc + 1, 2, 32'h5A, 32'hFF, "enable");
    wr(3'd4, 8'h5A);
    wr(3'd4, 8'hFF);

    // reset in the 8th cycle of a decimal conversion
    wr(3'd6, 8'h29);
    wr(3'd2, 8'h01);
    wr(3'd0, 8'h39);
    c = cyc;
    expect_at(c + 7, 3, 32'h1, 32'h1, "abort_busy_pre");
    expect_at(c + 7, 1, 32'h0000_0900, '1, "abort_dig_pre");
    wr(3'd1, 8'h30);
    wait_to(c + 7);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    r_rel = cyc;
    expect_at(c + 8, 2, 32'hFF, 32'hFF, "abort_dig_en");
    for (int k = 8; k <= 20; k++) begin
      expect_at(c + k, 1, 32'h0, '1, "abort_dig");
      expect_at(c + k, 3, 32'h0, 32'h1, "abort_busy");
    end
    rd(3'd2, 8'h00, 8'hFF, "abort_mode");
    wait_to(c + 22);

    for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0",
               q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
